// File: rtl/sched_pkg.sv
// sched_pkg: shared types and defaults for the mode scheduler
package sched_pkg;
  typedef enum logic {done = 1'b0, start = 1'b1} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} sched_state_t;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mode_sched_rr_pick.sv
// rr_pick: combinational round-robin winner select starting after last
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);
  localparam int W = $clog2(NREQ);
  logic [W-1:0] idx;
  logic found;
  always_comb begin
    winner = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = W'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/mode_sched.sv
// mode_sched: round-robin owner of a shared worker, driving its mode start->done
module mode_sched import sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    wk_ack,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output mode_t                   mode,
  output logic                    job_done,
  output logic                    timeout_err,
  output logic                    idle
);
  localparam int W = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  sched_state_t state, state_d;
  logic [NREQ-1:0] grant_d;
  logic [W-1:0] owner_d, last, last_d, winner;
  logic [CW-1:0] cnt, cnt_d;
  mode_t mode_d;
  logic job_done_d, timeout_err_d, valid;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req),
    .last(last),
    .winner(winner),
    .valid(valid)
  );
  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    last_d = last;
    mode_d = mode;
    cnt_d = cnt;
    job_done_d = 1'b0;
    timeout_err_d = 1'b0;
    case (state)
      IDLE: if (valid) begin
        state_d = RUN;
        grant_d = NREQ'(1) << winner;
        owner_d = winner;
        mode_d = start;
        cnt_d = '0;
      end
      RUN: begin
        cnt_d = cnt + CW'(1);
        // ack wins over a coincident timeout
        if (wk_ack || cnt == CW'(TIMEOUT - 1)) begin
          state_d = RELEASE;
          mode_d = done;
          job_done_d = wk_ack;
          timeout_err_d = !wk_ack;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
        last_d = owner;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last <= W'(NREQ - 1);
      mode <= done;
      cnt <= '0;
      job_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      owner <= owner_d;
      last <= last_d;
      mode <= mode_d;
      cnt <= cnt_d;
      job_done <= job_done_d;
      timeout_err <= timeout_err_d;
    end
  end
  assign idle = state == IDLE;
endmodule

// File: tb/tb_mode_sched.sv
// tb_mode_sched: scoreboard bench; expected jobs queued at stimulus, checked at each end pulse
module tb_mode_sched;
  import sched_pkg::*;
  typedef struct {
    logic [3:0] g;
    int o;
    bit k;
    int n;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic wk_ack = 1'b0;
  logic [3:0] grant;
  logic [1:0] owner;
  mode_t mode;
  logic job_done, timeout_err, idle;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int runlen = 0;
  logic [3:0] prev_g = '0;
  exp_t sb[$];
  exp_t e;
  mode_sched #(.NREQ(4), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .wk_ack(wk_ack),
    .grant(grant),
    .owner(owner),
    .mode(mode),
    .job_done(job_done),
    .timeout_err(timeout_err),
    .idle(idle)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [3:0] g, input int o, input bit k, input int n);
    exp_t x;
    x.g = g;
    x.o = o;
    x.k = k;
    x.n = n;
    sb.push_back(x);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_grant();
    int t = 0;
    while (grant != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (grant == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("grant_wait_expired", 0, 1);
  endtask
  task automatic run_ack(input int n);
    repeat (n - 1) @(negedge clk);
    wk_ack = 1'b1;
    @(negedge clk);
    wk_ack = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (!idle && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_wait_expired", 0, 1);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_g = '0;
      runlen = 0;
    end else begin
      if (grant != 0 && prev_g == 0) runlen = 0;
      if (mode == start) runlen++;
      if (job_done || timeout_err) begin
        check("pulse_excl", 32'(job_done & timeout_err), 0);
        if (sb.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          e = sb.pop_front();
          check("job_grant", 32'(grant), 32'(e.g));
          check("job_owner", 32'(owner), 32'(e.o));
          check("job_kind", 32'(timeout_err), 32'(e.k));
          check("job_len", 32'(runlen), 32'(e.n));
        end
      end
      prev_g = grant;
    end
  end
  initial begin
    int tprev;
    logic [3:0] fo [5];
    fo = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tprev = 0;
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_mode", 32'(mode), 32'(done));
    check("rst_idle", 32'(idle), 1);
    check("rst_pulses", 32'({job_done, timeout_err}), 0);
    for (int i = 0; i < 20; i++) begin
      wk_ack = (i % 4 == 1);
      @(negedge clk);
      check("idle_hold", 32'({grant, mode, idle, job_done, timeout_err}), 32'(8'b0000_0_1_00));
    end
    wk_ack = 1'b0;
    push(4'b0100, 2, 1'b0, 5);
    req = 4'b0100;
    wait_grant();
    req = '0;
    check("single_grant", 32'(grant), 32'(4'b0100));
    check("single_owner", 32'(owner), 2);
    check("single_mode", 32'(mode), 32'(start));
    check("single_busy", 32'(idle), 0);
    run_ack(5);
    check("single_rel_grant", 32'(grant), 32'(4'b0100));
    check("single_rel_mode", 32'(mode), 32'(done));
    @(negedge clk);
    check("single_drop", 32'({grant, idle}), 32'(5'b0000_1));
    do_reset();
    for (int j = 0; j < 5; j++) push(fo[j], j % 4, 1'b0, 1);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_grant();
      if (j == 4) req = '0;
      check("fair_grant", 32'(grant), 32'(fo[j]));
      if (j > 0) check("fair_period", 32'(cyc - tprev), 3);
      tprev = cyc;
      run_ack(1);
    end
    wait_idle();
    push(4'b0010, 1, 1'b1, 15);
    req = 4'b0010;
    wait_grant();
    req = '0;
    repeat (20) @(negedge clk);
    wait_idle();
    push(4'b1000, 3, 1'b0, 15);
    req = 4'b1000;
    wait_grant();
    req = '0;
    run_ack(15);
    wait_idle();
    req = 4'b0100;
    wait_grant();
    check("mid_owner", 32'(owner), 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    check("mid_rst_state", 32'({grant, mode, owner, job_done, timeout_err, idle}), 32'(10'b0000_0_00_0_0_1));
    rst_n = 1'b1;
    push(4'b0001, 0, 1'b0, 1);
    wait_grant();
    req = '0;
    check("post_rst_grant", 32'(grant), 32'(4'b0001));
    run_ack(1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
